mac_req_arb: RTL and testbench
==============================

MAC_REQ_ARB -- requirements
Module: mac_req_arb

Interface
REQ-001 SHALL have parameter AGE_MAX, default 8, meaning the number of lost arbitration cycles after which a waiting channel is force-granted (range 1..15).
REQ-002 SHALL have port clk, input, 1, the single clock; all state is updated on its rising edge.
REQ-003 SHALL have port resetn, input, 1, asynchronous active-low reset.
REQ-004 SHALL have ports iMAC_ValidRd/iMAC_AddrRd/iMAC_TagRd/iMAC_IdRd/iMAC_LenRd/iMAC_QoSRd, inputs, 1/32/4/3/2/4, read request channel.
REQ-005 SHALL have port oMAC_ReadyRd, output, 1, read request accepted this cycle when high with iMAC_ValidRd.
REQ-006 SHALL have ports iMAC_ValidWr/iMAC_AddrWr/iMAC_TagWr/iMAC_IdWr/iMAC_LenWr/iMAC_QoSWr, inputs, 1/32/4/3/2/4, write request channel.
REQ-007 SHALL have port oMAC_ReadyWr, output, 1, write request accepted this cycle when high with iMAC_ValidWr.
REQ-008 SHALL have ports oArb_Valid/oArb_Addr/oArb_Tag/oArb_Id/oArb_Len/oArb_Wr, outputs, 1/32/4/3/2/1, registered granted command to the SDRAM command sequencer; oArb_Wr=1 for write.
REQ-009 SHALL have port iArb_Ready, input, 1, downstream consumes the output command when high with oArb_Valid.

Function
REQ-010 SHALL hold one output command register with states EMPTY (oArb_Valid=0) and FULL (oArb_Valid=1).
REQ-011 SHALL be able to accept a request in a cycle iff state is EMPTY or (FULL and iArb_Ready=1).
REQ-012 SHALL assert at most one of oMAC_ReadyRd/oMAC_ReadyWr per cycle, and only toward the selected channel whose valid is high.
REQ-013 SHALL present an accepted request on the output registers the next cycle (latency 1), sustaining 1 command/cycle when iArb_Ready stays high.
REQ-014 SHALL keep all oArb_* outputs stable while FULL and iArb_Ready=0.
REQ-015 SHALL transition FULL->EMPTY on iArb_Ready=1 with no accept; FULL->FULL with new contents on iArb_Ready=1 with accept; EMPTY->FULL on accept.
REQ-016 SHALL select, when only one channel is valid, that channel.
REQ-017 SHALL select, when both are valid, the channel whose age counter equals AGE_MAX; else the strictly higher QoS (unsigned); else the channel not granted most recently (round-robin bit, reset value selects read first).
REQ-018 SHALL resolve both age counters at AGE_MAX by the round-robin bit.
REQ-019 SHALL keep a 4-bit age counter per channel: +1 in an accept cycle where that channel is valid and not granted, saturating at AGE_MAX; cleared when that channel is granted; unchanged in non-accept cycles.
REQ-020 SHALL toggle the round-robin bit to point away from the granted channel on every accept.
REQ-021 SHALL pass Addr/Tag/Id/Len unmodified from the granted channel.

Reset
REQ-022 SHALL, while resetn=0, force oArb_Valid=0, oArb_Addr=0, oArb_Tag=0, oArb_Id=0, oArb_Len=0, oArb_Wr=0, oMAC_ReadyRd=0, oMAC_ReadyWr=0, age counters=0, round-robin bit=read, state EMPTY.
REQ-023 SHALL discard any held command when reset asserts mid-operation; nothing is replayed after release.
REQ-024 SHALL accept requests from the first rising clk edge after resetn deasserts.

Configuration
REQ-025 SHALL, with MAC_ARB_RAW_HAZARD_EN defined, grant the write when both channels are valid and iMAC_AddrRd[31:2]==iMAC_AddrWr[31:2], overriding QoS, age and round-robin, and clear the write age counter only.
REQ-026 SHALL, without MAC_ARB_RAW_HAZARD_EN, apply REQ-017 regardless of address match.

Verification
REQ-027 Write only: Valid=1, Addr=32'h2345_F220, Id=3'b101, Len=2'b10, QoS=4'b0110, iArb_Ready=1 -> oMAC_ReadyWr=1 same cycle; next cycle oArb_Valid=1, oArb_Wr=1, oArb_Addr=32'h2345_F220, Id=5, Len=2.
REQ-028 Both valid, QoSRd=4'h3, QoSWr=4'h9, iArb_Ready=1 -> write granted first, read next cycle; read age 1 then 0.
REQ-029 Both valid continuously, equal QoS=4'h5 -> grants alternate Rd,Wr,Rd,Wr from reset.
REQ-030 Read QoS=4'hF, write QoS=4'h0 both held valid, AGE_MAX=8 -> write granted on the 9th accept cycle, then reads resume.
REQ-031 iArb_Ready=0 for 5 cycles after one accept -> oArb_* constant, both ready outputs 0; resetn pulsed low -> oArb_Valid=0 immediately.
REQ-032 MAC_ARB_RAW_HAZARD_EN defined, AddrRd=AddrWr=32'h0000_1000, QoSRd=4'hF, QoSWr=4'h0 -> write granted first; macro undefined -> read granted first.

Source files
------------

// File: rtl/mac_req_arb.sv
// Two-channel read/write request arbiter feeding a one-deep command register.
// Optional MAC_ARB_RAW_HAZARD_EN: same-word read/write collision grants the write.
module mac_req_arb #(
  parameter int AGE_MAX = 8
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        iMAC_ValidRd,
  input  logic [31:0] iMAC_AddrRd,
  input  logic [3:0]  iMAC_TagRd,
  input  logic [2:0]  iMAC_IdRd,
  input  logic [1:0]  iMAC_LenRd,
  input  logic [3:0]  iMAC_QoSRd,
  output logic        oMAC_ReadyRd,
  input  logic        iMAC_ValidWr,
  input  logic [31:0] iMAC_AddrWr,
  input  logic [3:0]  iMAC_TagWr,
  input  logic [2:0]  iMAC_IdWr,
  input  logic [1:0]  iMAC_LenWr,
  input  logic [3:0]  iMAC_QoSWr,
  output logic        oMAC_ReadyWr,
  output logic        oArb_Valid,
  output logic [31:0] oArb_Addr,
  output logic [3:0]  oArb_Tag,
  output logic [2:0]  oArb_Id,
  output logic [1:0]  oArb_Len,
  output logic        oArb_Wr,
  input  logic        iArb_Ready
);

  localparam logic [3:0] AGE_LIM = 4'(AGE_MAX);
  localparam logic [0:0] EMPTY = 1'b0;
  localparam logic [0:0] FULL  = 1'b1;

  logic [0:0] state;
  logic       rr_wr;
  logic [3:0] age_rd;
  logic [3:0] age_wr;
  logic       can_acc;
  logic       both;
  logic       sat_rd;
  logic       sat_wr;
  logic       hazard;
  logic       sel_wr;
  logic       gnt_rd;
  logic       gnt_wr;
  logic       acc;

  always_comb begin
    can_acc = (state == EMPTY) || iArb_Ready;
    both    = iMAC_ValidRd && iMAC_ValidWr;
    sat_rd  = (age_rd == AGE_LIM);
    sat_wr  = (age_wr == AGE_LIM);
`ifdef MAC_ARB_RAW_HAZARD_EN
    hazard  = (iMAC_AddrRd[31:2] == iMAC_AddrWr[31:2]);
`else
    hazard  = 1'b0;
`endif
    sel_wr  = 1'b0;
    if (!both)
      sel_wr = iMAC_ValidWr;
    else if (hazard)
      sel_wr = 1'b1;
    else if (sat_rd && sat_wr)
      sel_wr = rr_wr;
    else if (sat_rd)
      sel_wr = 1'b0;
    else if (sat_wr)
      sel_wr = 1'b1;
    else if (iMAC_QoSWr > iMAC_QoSRd)
      sel_wr = 1'b1;
    else if (iMAC_QoSRd > iMAC_QoSWr)
      sel_wr = 1'b0;
    else
      sel_wr = rr_wr;
    // Ready outputs are combinational, so gate them off while in reset
    gnt_wr = resetn && can_acc && iMAC_ValidWr && sel_wr;
    gnt_rd = resetn && can_acc && iMAC_ValidRd && !sel_wr;
    acc    = gnt_rd || gnt_wr;
  end

  assign oMAC_ReadyRd = gnt_rd;
  assign oMAC_ReadyWr = gnt_wr;
  assign oArb_Valid   = (state == FULL);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= EMPTY;
      oArb_Addr <= '0;
      oArb_Tag  <= '0;
      oArb_Id   <= '0;
      oArb_Len  <= '0;
      oArb_Wr   <= 1'b0;
    end else if (acc) begin
      state     <= FULL;
      oArb_Wr   <= gnt_wr;
      oArb_Addr <= gnt_wr ? iMAC_AddrWr : iMAC_AddrRd;
      oArb_Tag  <= gnt_wr ? iMAC_TagWr  : iMAC_TagRd;
      oArb_Id   <= gnt_wr ? iMAC_IdWr   : iMAC_IdRd;
      oArb_Len  <= gnt_wr ? iMAC_LenWr  : iMAC_LenRd;
    end else if (iArb_Ready) begin
      state <= EMPTY;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rr_wr  <= 1'b0;
      age_rd <= '0;
      age_wr <= '0;
    end else if (acc) begin
      rr_wr <= gnt_rd;
      if (gnt_rd)
        age_rd <= '0;
      else if (iMAC_ValidRd && !sat_rd)
        age_rd <= age_rd + 4'd1;
      if (gnt_wr)
        age_wr <= '0;
      else if (iMAC_ValidWr && !sat_wr)
        age_wr <= age_wr + 4'd1;
    end
  end

endmodule

// File: tb/tb_mac_req_arb.sv
// Self-checking bench for mac_req_arb: vector table plus corner sequences.
// Expected commands are queued on accept and compared when registered.
module tb_mac_req_arb;

  logic        clk = 1'b0;
  logic        resetn;
  logic        iMAC_ValidRd;
  logic [31:0] iMAC_AddrRd;
  logic [3:0]  iMAC_TagRd;
  logic [2:0]  iMAC_IdRd;
  logic [1:0]  iMAC_LenRd;
  logic [3:0]  iMAC_QoSRd;
  logic        oMAC_ReadyRd;
  logic        iMAC_ValidWr;
  logic [31:0] iMAC_AddrWr;
  logic [3:0]  iMAC_TagWr;
  logic [2:0]  iMAC_IdWr;
  logic [1:0]  iMAC_LenWr;
  logic [3:0]  iMAC_QoSWr;
  logic        oMAC_ReadyWr;
  logic        oArb_Valid;
  logic [31:0] oArb_Addr;
  logic [3:0]  oArb_Tag;
  logic [2:0]  oArb_Id;
  logic [1:0]  oArb_Len;
  logic        oArb_Wr;
  logic        iArb_Ready;

  mac_req_arb #(.AGE_MAX(8)) dut (
    .clk(clk), .resetn(resetn),
    .iMAC_ValidRd(iMAC_ValidRd), .iMAC_AddrRd(iMAC_AddrRd),
    .iMAC_TagRd(iMAC_TagRd), .iMAC_IdRd(iMAC_IdRd),
    .iMAC_LenRd(iMAC_LenRd), .iMAC_QoSRd(iMAC_QoSRd),
    .oMAC_ReadyRd(oMAC_ReadyRd),
    .iMAC_ValidWr(iMAC_ValidWr), .iMAC_AddrWr(iMAC_AddrWr),
    .iMAC_TagWr(iMAC_TagWr), .iMAC_IdWr(iMAC_IdWr),
    .iMAC_LenWr(iMAC_LenWr), .iMAC_QoSWr(iMAC_QoSWr),
    .oMAC_ReadyWr(oMAC_ReadyWr),
    .oArb_Valid(oArb_Valid), .oArb_Addr(oArb_Addr),
    .oArb_Tag(oArb_Tag), .oArb_Id(oArb_Id),
    .oArb_Len(oArb_Len), .oArb_Wr(oArb_Wr),
    .iArb_Ready(iArb_Ready)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        wr;
    logic [31:0] addr;
    logic [3:0]  tag;
    logic [2:0]  id;
    logic [1:0]  len;
  } cmd_t;

  typedef struct {
    logic        vrd;
    logic [3:0]  qrd;
    logic [31:0] ard;
    logic        vwr;
    logic [3:0]  qwr;
    logic [31:0] awr;
    logic        rdy;
    logic        erd;
    logic        ewr;
  } vec_t;

  int   checks = 0;
  int   errors = 0;
  logic exp_valid = 1'b0;
  cmd_t held = '0;
  cmd_t sb[$];
  vec_t tbl[13];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic vrd, input logic [3:0] qrd,
                       input logic [31:0] ard, input logic vwr,
                       input logic [3:0] qwr, input logic [31:0] awr,
                       input logic rdy);
    iMAC_ValidRd = vrd;
    iMAC_QoSRd   = qrd;
    iMAC_AddrRd  = ard;
    iMAC_TagRd   = 4'($urandom);
    iMAC_IdRd    = 3'($urandom);
    iMAC_LenRd   = 2'($urandom);
    iMAC_ValidWr = vwr;
    iMAC_QoSWr   = qwr;
    iMAC_AddrWr  = awr;
    iMAC_TagWr   = 4'($urandom);
    iMAC_IdWr    = 3'($urandom);
    iMAC_LenWr   = 2'($urandom);
    iArb_Ready   = rdy;
  endtask

  // Inputs are set just after a rising edge; this checks one clock cycle
  task automatic step(input logic erd, input logic ewr, input string nm);
    cmd_t c;
    logic acc;
    @(negedge clk);
    chk({nm, ".ready_rd"}, 64'(oMAC_ReadyRd), 64'(erd));
    chk({nm, ".ready_wr"}, 64'(oMAC_ReadyWr), 64'(ewr));
    acc = erd | ewr;
    if (acc) begin
      if (ewr)
        c = '{1'b1, iMAC_AddrWr, iMAC_TagWr, iMAC_IdWr, iMAC_LenWr};
      else
        c = '{1'b0, iMAC_AddrRd, iMAC_TagRd, iMAC_IdRd, iMAC_LenRd};
      sb.push_back(c);
    end
    @(posedge clk);
    #1;
    if (acc)
      exp_valid = 1'b1;
    else if (iArb_Ready)
      exp_valid = 1'b0;
    chk({nm, ".valid"}, 64'(oArb_Valid), 64'(exp_valid));
    if (acc)
      held = sb.pop_front();
    if (exp_valid)
      chk({nm, ".cmd"},
          64'({oArb_Wr, oArb_Addr, oArb_Tag, oArb_Id, oArb_Len}),
          64'(held));
  endtask

  task automatic do_reset(input string nm);
    resetn = 1'b0;
    #1;
    chk({nm, ".rst_valid"}, 64'(oArb_Valid), 64'd0);
    chk({nm, ".rst_cmd"},
        64'({oArb_Wr, oArb_Addr, oArb_Tag, oArb_Id, oArb_Len}), 64'd0);
    chk({nm, ".rst_ready"}, 64'({oMAC_ReadyRd, oMAC_ReadyWr}), 64'd0);
    drive(0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    resetn    = 1'b1;
    exp_valid = 1'b0;
    sb.delete();
  endtask

  initial begin
    tbl[0]  = '{0, 4'h0, 32'h0000_0100, 0, 4'h0, 32'h0000_0200, 1, 0, 0};
    tbl[1]  = '{0, 4'h0, 32'h0000_0100, 1, 4'h6, 32'h2345_F220, 1, 0, 1};
    tbl[2]  = '{1, 4'h3, 32'h0000_0300, 1, 4'h9, 32'h0000_0400, 1, 0, 1};
    tbl[3]  = '{1, 4'h3, 32'h0000_0300, 0, 4'h9, 32'h0000_0400, 1, 1, 0};
    tbl[4]  = '{1, 4'h0, 32'h0000_0500, 0, 4'h0, 32'h0000_0400, 1, 1, 0};
    tbl[5]  = '{1, 4'h5, 32'h0000_0600, 1, 4'h5, 32'h0000_0700, 1, 0, 1};
    tbl[6]  = '{1, 4'h5, 32'h0000_0600, 1, 4'h5, 32'h0000_0700, 1, 1, 0};
    tbl[7]  = '{1, 4'h0, 32'h0000_0800, 0, 4'h0, 32'h0000_0700, 0, 0, 0};
    tbl[8]  = '{1, 4'h5, 32'h0000_0800, 1, 4'h5, 32'h0000_0900, 0, 0, 0};
    tbl[9]  = '{0, 4'h0, 32'h0000_0800, 0, 4'h0, 32'h0000_0900, 1, 0, 0};
    tbl[10] = '{1, 4'h2, 32'h0000_0A00, 0, 4'h0, 32'h0000_0900, 0, 1, 0};
    tbl[11] = '{0, 4'h0, 32'h0000_0A00, 1, 4'h4, 32'h0000_0B00, 0, 0, 0};
    tbl[12] = '{0, 4'h0, 32'h0000_0A00, 1, 4'h4, 32'h0000_0B00, 1, 0, 1};

    resetn = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    do_reset("init");

    for (int i = 0; i < 13; i++) begin
      drive(tbl[i].vrd, tbl[i].qrd, tbl[i].ard,
            tbl[i].vwr, tbl[i].qwr, tbl[i].awr, tbl[i].rdy);
      if (i == 1) begin
        iMAC_IdWr  = 3'b101;
        iMAC_LenWr = 2'b10;
      end
      step(tbl[i].erd, tbl[i].ewr, $sformatf("vec%0d", i));
    end

    // Equal QoS alternates starting with read
    do_reset("rr");
    for (int k = 0; k < 6; k++) begin
      drive(1, 4'h5, 32'h0000_1100, 1, 4'h5, 32'h0000_2200, 1);
      step(k % 2 == 0, k % 2 == 1, $sformatf("rr%0d", k));
    end

    // Starved write forced in on the 9th accept
    do_reset("age");
    for (int k = 0; k < 12; k++) begin
      drive(1, 4'hF, 32'h0000_3300, 1, 4'h0, 32'h0000_4400, 1);
      step(k != 8, k == 8, $sformatf("age%0d", k));
    end

    // Back-pressure hold, then reset mid-operation
    do_reset("hold");
    drive(1, 4'h1, 32'h0000_5500, 0, 4'h0, 32'h0000_6600, 1);
    step(1, 0, "hold_acc");
    for (int k = 0; k < 5; k++) begin
      drive(1, 4'h1, 32'h0000_5504, 1, 4'h2, 32'h0000_6600, 0);
      step(0, 0, $sformatf("hold%0d", k));
    end
    iArb_Ready = 1'b1;
    do_reset("midrst");
    drive(0, 0, 0, 0, 0, 0, 1);
    step(0, 0, "post_rst");

    // Same-word collision
    drive(1, 4'hF, 32'h0000_1000, 1, 4'h0, 32'h0000_1000, 1);
`ifdef MAC_ARB_RAW_HAZARD_EN
    step(0, 1, "raw0");
`else
    step(1, 0, "raw0");
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
